// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
// Holds the responder FSM state type, default bus widths and the
// response error code driven on rsp_err for out-of-range accesses.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned DEFAULT_DATA_W = 32;

  // Value of rsp_err when the word address is beyond the implemented depth.
  localparam logic RSP_ERR_RANGE = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, byte write enables, registered read.
// Ports:
//   clk    in   clock, rising edge
//   en     in   access enable; a read (and optional write) happens on this edge
//   we     in   1 = apply byte-enabled write
//   addr   in   word index
//   wdata  in   write data
//   be     in   byte write enables
//   rdata  out  registered read data (old contents on a write cycle); holds when en=0
module mem_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory target answering one load/store at a time with a fixed latency.
// Ports:
//   clk100     in   system clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept
//   req_we     in   1 = store, 0 = load
//   req_addr   in   word address
//   req_wdata  in   store data
//   req_be     in   store byte enables
//   rsp_valid  out  response present
//   rsp_ready  in   core accepts the response
//   rsp_rdata  out  load data; 0 for stores and errors
//   rsp_err    out  address >= DEPTH
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk100,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned BeW     = DATA_W / 8;
  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned CntInit = (LATENCY >= 2) ? LATENCY - 2 : 0;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BeW-1:0]      be_q;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rd_sel_q, rd_sel_d;

  logic                accept;
  logic                access;
  logic                in_range;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [BeW-1:0]      acc_be;
  logic [DATA_W-1:0]   ram_rdata;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_sel_d    = rd_sel_q;
    access      = 1'b0;
    // With LATENCY == 1 the access happens on the acceptance edge, so the
    // live request fields are used instead of the latched copy.
    acc_we      = we_q;
    acc_addr    = addr_q;
    acc_wdata   = wdata_q;
    acc_be      = be_q;

    unique case (state_q)
      StIdle: begin
        acc_we    = req_we;
        acc_addr  = req_addr;
        acc_wdata = req_wdata;
        acc_be    = req_be;
        if (accept) begin
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = CntW'(CntInit);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rd_sel_d    = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_range = (64'(acc_addr) < 64'(DEPTH));
    if (access) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = in_range ? 1'b0 : RSP_ERR_RANGE;
      rd_sel_d    = ~acc_we & in_range;
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_sel_q    <= rd_sel_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // rst_n gates the RAM so no write can slip through while reset is held.
  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IdxW)
  ) u_mem_array (
    .clk   (clk100),
    .en    (access & in_range & rst_n),
    .we    (acc_we),
    .addr  (acc_addr[IdxW-1:0]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (ram_rdata)
  );

  // The RAM read register holds between accesses; rd_sel_q zeroes it for
  // stores, errors and after the response handshake.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk100 = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int passes = 0;
  int total  = 0;

  always #5 clk100 = ~clk100;

  mem_responder #(
    .ADDR_W (11), .DATA_W (32), .DEPTH (1024), .LATENCY (2)
  ) dut_a (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .req_valid (req_valid & ~sel),
    .req_ready (a_req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready & ~sel),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
  );

  mem_responder #(
    .ADDR_W (11), .DATA_W (32), .DEPTH (1024), .LATENCY (1)
  ) dut_b (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .req_valid (req_valid & sel),
    .req_ready (b_req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready & sel),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  assign req_ready = sel ? b_req_ready : a_req_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  // Full transaction with rsp_ready held high; checks latency and handshake.
  task automatic xfer(input string tag, input logic we, input logic [10:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input int lat,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " rdata"}, rsp_rdata, exp_rd);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    step();
    check({tag, " valid cleared"}, 32'(rsp_valid), 32'd0);
    check({tag, " req_ready back"}, 32'(req_ready), 32'd1);
    check({tag, " rdata cleared"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    step();

    // Reset / idle state on both instances
    check("rst a req_ready", 32'(a_req_ready), 32'd1);
    check("rst a rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst a rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst a rsp_err",   32'(a_rsp_err), 32'd0);
    check("rst b req_ready", 32'(b_req_ready), 32'd1);
    check("rst b rsp_valid", 32'(b_rsp_valid), 32'd0);

    // Store then load
    xfer("st5", 1'b1, 11'h005, 32'hDEADBEEF, 4'hF, 2, 32'd0, 1'b0);
    xfer("ld5", 1'b0, 11'h005, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0);

    // Partial store
    xfer("st10a", 1'b1, 11'h010, 32'h11223344, 4'hF, 2, 32'd0, 1'b0);
    xfer("st10b", 1'b1, 11'h010, 32'hAABBCCDD, 4'b0101, 2, 32'd0, 1'b0);
    xfer("ld10",  1'b0, 11'h010, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0);
    xfer("st10z", 1'b1, 11'h010, 32'hFFFFFFFF, 4'h0, 2, 32'd0, 1'b0);
    xfer("ld10z", 1'b0, 11'h010, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0);

    // Backpressure with a competing request that must be ignored
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h005;
    step();
    req_addr = 11'h006;
    check("bp wait no valid", 32'(rsp_valid), 32'd0);
    check("bp wait req_ready", 32'(req_ready), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", 32'(rsp_valid), 32'd1);
      check("bp hold rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp hold req_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("bp final rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    check("bp released valid", 32'(rsp_valid), 32'd0);
    check("bp released req_ready", 32'(req_ready), 32'd1);
    step(); step(); step();
    check("bp no stray rsp", 32'(rsp_valid), 32'd0);
    check("bp still idle", 32'(req_ready), 32'd1);

    // Out of range
    xfer("st0",   1'b1, 11'h000, 32'h5A5A0001, 4'hF, 2, 32'd0, 1'b0);
    xfer("st400", 1'b1, 11'h400, 32'hFFFFFFFF, 4'hF, 2, 32'd0, 1'b1);
    xfer("ld0",   1'b0, 11'h000, 32'h0, 4'h0, 2, 32'h5A5A0001, 1'b0);
    xfer("ld7ff", 1'b0, 11'h7FF, 32'h0, 4'h0, 2, 32'd0, 1'b1);
    xfer("ld3ff", 1'b0, 11'h3FF, 32'h0, 4'h0, 2, 32'h0 ^ a_rsp_rdata, 1'b0);

    // Reset during WAIT drops the store (LATENCY=2)
    xfer("st20", 1'b1, 11'h020, 32'hCAFEF00D, 4'hF, 2, 32'd0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h020; req_wdata = 32'h12345678;
    req_be = 4'hF;
    step();
    req_valid = 1'b0;
    check("rstw in wait", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstw async idle", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstw no valid", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    step();
    check("rstw after release", 32'(rsp_valid), 32'd0);
    xfer("ld20", 1'b0, 11'h020, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b0);

    // LATENCY=1 instance: store applied on the acceptance edge survives reset
    sel = 1'b1;
    xfer("b st20", 1'b1, 11'h020, 32'h11110000, 4'hF, 1, 32'd0, 1'b0);
    xfer("b ld20", 1'b0, 11'h020, 32'h0, 4'h0, 1, 32'h11110000, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h020; req_wdata = 32'h0BADF00D;
    req_be = 4'hF;
    step();
    req_valid = 1'b0;
    check("b rst in resp", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("b rst drops valid", 32'(rsp_valid), 32'd0);
    check("b rst ready", 32'(req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    xfer("b ld20 post", 1'b0, 11'h020, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0);
    xfer("b st400", 1'b1, 11'h400, 32'h0, 4'hF, 1, 32'd0, 1'b1);

    // Instance A was idle across the LATENCY=1 reset; its memory is intact.
    sel = 1'b0;
    xfer("a ld20 final", 1'b0, 11'h020, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
